// File: rtl/sram_stream_master.sv
// Purpose: strided block initiator for one SRAM request stream; write data in, read data out via a credit-protected FIFO.
// Latency: first request one cycle after command accept; read data is visible on rd_* two cycles after its grant.
// Backpressure: holds each request until granted; read requests stall when queued plus in-flight reads reach FIFO_D.
module sram_stream_master #(
    parameter int ADDR_W = 12,
    parameter int Data_W = 16,
    parameter int LEN_W  = 8,
    parameter int FIFO_D = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_v,
    output logic              cmd_ready,
    input  logic              cmd_we,
    input  logic [ADDR_W-1:0] cmd_base,
    input  logic [ADDR_W-1:0] cmd_stride,
    input  logic [LEN_W-1:0]  cmd_len,
    input  logic              wd_v,
    output logic              wd_ready,
    input  logic [Data_W-1:0] wd_data,
    output logic              req_v,
    output logic              req_we,
    output logic [ADDR_W-1:0] req_addr,
    output logic [Data_W-1:0] req_wdata,
    input  logic              req_ready,
    input  logic              rsp_v,
    input  logic [Data_W-1:0] rsp_rdata,
    output logic              rd_v,
    input  logic              rd_ready,
    output logic [Data_W-1:0] rd_data,
    output logic              rd_last,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int PTR_W = (FIFO_D > 1) ? $clog2(FIFO_D) : 1;
    localparam int CNT_W = $clog2(FIFO_D + 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]        state_q, state_d;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] stride_q;
    logic [LEN_W-1:0]  len_q;
    logic [LEN_W-1:0]  issued_q, issued_d;
    logic              inflight_rd_q;
    logic              inflight_last_q;
    logic              err_q;

    logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [Data_W:0]   mem_q [FIFO_D];

    logic              run;
    logic              grant;
    logic              last_word;
    logic [CNT_W:0]    credit_used;
    logic              credit_ok;
    logic              push;
    logic              pop;

    // Request side: credit counts both queued words and the read whose response is due now,
    // so the sum can only stay equal or shrink while a request is held.
    always_comb begin
        run         = (state_q == S_RUN);
        credit_used = {1'b0, cnt_q} + (CNT_W + 1)'(inflight_rd_q);
        credit_ok   = credit_used < (CNT_W + 1)'(FIFO_D);
        req_v       = run & (we_q ? wd_v : credit_ok);
        grant       = req_v & req_ready;
        last_word   = (issued_q == (len_q - LEN_W'(1)));
        req_we      = we_q;
        req_addr    = addr_q;
        req_wdata   = wd_data;
        wd_ready    = grant & we_q;
        cmd_ready   = (state_q == S_IDLE);
        busy        = (state_q != S_IDLE);
        done        = (state_q == S_DONE);
        err         = err_q;
        push        = inflight_rd_q & rsp_v;
        pop         = rd_v & rd_ready;
    end

    // Next-state logic; an empty command passes through DRAIN so done keeps the same offset as
    // a real burst. DRAIN always lasts one cycle: no grant can happen there, and the response to
    // the last grant lands while in DRAIN.
    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        issued_d = issued_q;
        case (state_q)
            S_IDLE: begin
                if (cmd_v) begin
                    addr_d   = cmd_base;
                    issued_d = '0;
                    state_d  = (cmd_len == '0) ? S_DRAIN : S_RUN;
                end
            end
            S_RUN: begin
                if (grant) begin
                    issued_d = issued_q + LEN_W'(1);
                    addr_d   = addr_q + stride_q;
                    if (last_word) begin
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Control state, command latch, in-flight tracking and sticky missing-response flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= S_IDLE;
            we_q            <= 1'b0;
            addr_q          <= '0;
            stride_q        <= '0;
            len_q           <= '0;
            issued_q        <= '0;
            inflight_rd_q   <= 1'b0;
            inflight_last_q <= 1'b0;
            err_q           <= 1'b0;
        end else begin
            state_q         <= state_d;
            addr_q          <= addr_d;
            issued_q        <= issued_d;
            inflight_rd_q   <= grant & ~we_q;
            inflight_last_q <= last_word;
            if (state_q == S_IDLE && cmd_v) begin
                we_q     <= cmd_we;
                stride_q <= cmd_stride;
                len_q    <= cmd_len;
            end
            if (inflight_rd_q && !rsp_v) begin
                err_q <= 1'b1;
            end
        end
    end

    // Read FIFO pointers and occupancy; simultaneous push and pop leave the count unchanged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= (wr_ptr_q == PTR_W'(FIFO_D - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= (rd_ptr_q == PTR_W'(FIFO_D - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   cnt_q <= cnt_q + CNT_W'(1);
                2'b01:   cnt_q <= cnt_q - CNT_W'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    // FIFO storage holds {last, data}; it needs no reset because rd_v gates every read of it.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {inflight_last_q, rsp_rdata};
        end
    end

    // Read stream outputs come straight from the head entry.
    always_comb begin
        rd_v    = (cnt_q != '0);
        rd_data = mem_q[rd_ptr_q][Data_W-1:0];
        rd_last = rd_v & mem_q[rd_ptr_q][Data_W];
    end

endmodule

// File: tb/tb_sram_stream_master.sv
// Directed bench for sram_stream_master with a one-cycle-latency SRAM responder (mem[a] = a ^ 0x5A5A).
// Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
// A monitor logs grants, pops, done pulses and held-request stability for the directed steps to inspect.
module tb_sram_stream_master;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_v;
    logic        cmd_ready;
    logic        cmd_we;
    logic [11:0] cmd_base;
    logic [11:0] cmd_stride;
    logic [7:0]  cmd_len;
    logic        wd_v;
    logic        wd_ready;
    logic [15:0] wd_data;
    logic        req_v;
    logic        req_we;
    logic [11:0] req_addr;
    logic [15:0] req_wdata;
    logic        req_ready;
    logic        rsp_v;
    logic [15:0] rsp_rdata;
    logic        rd_v;
    logic        rd_ready;
    logic [15:0] rd_data;
    logic        rd_last;
    logic        busy;
    logic        done;
    logic        err;

    int          n_checks = 0;
    int          n_err    = 0;
    int          cyc      = 0;
    int          acc_cyc  = 0;
    logic        drop_rsp = 1'b0;

    logic [28:0] gq[$];
    int          gcyc[$];
    logic [16:0] pq[$];
    int          done_cnt = 0;
    int          done_cyc = -1;
    int          wdr_cnt  = 0;
    logic        rdv_seen = 1'b0;
    logic        reqv_seen = 1'b0;
    logic        hold_prev = 1'b0;
    logic [28:0] hold_val = '0;

    sram_stream_master #(
        .ADDR_W(12), .Data_W(16), .LEN_W(8), .FIFO_D(4)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_v(cmd_v), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
        .cmd_base(cmd_base), .cmd_stride(cmd_stride), .cmd_len(cmd_len),
        .wd_v(wd_v), .wd_ready(wd_ready), .wd_data(wd_data),
        .req_v(req_v), .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_ready(req_ready), .rsp_v(rsp_v), .rsp_rdata(rsp_rdata),
        .rd_v(rd_v), .rd_ready(rd_ready), .rd_data(rd_data), .rd_last(rd_last),
        .busy(busy), .done(done), .err(err)
    );

    initial forever #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // SRAM responder: a grant seen in one cycle produces rsp_v in the next.
    initial begin
        logic        g_any;
        logic        g_rd;
        logic        drop;
        logic [11:0] a;
        rsp_v     = 1'b0;
        rsp_rdata = 16'h0000;
        forever begin
            @(negedge clk);
            g_any = req_v && req_ready;
            g_rd  = g_any && !req_we;
            a     = req_addr;
            drop  = drop_rsp;
            @(posedge clk);
            #1;
            rsp_v     = g_any && !drop;
            rsp_rdata = g_rd ? ({4'h0, a} ^ 16'h5A5A) : 16'hDEAD;
        end
    end

    // Monitor: logs activity and checks that a denied request stays unchanged.
    initial forever begin
        @(negedge clk);
        if (rst_n) begin
            if (hold_prev) begin
                chk("hold_stable", {3'b0, req_v, req_we, req_addr, (req_we ? req_wdata : 16'h0)},
                    {3'b0, 1'b1, hold_val[28], hold_val[27:16], (hold_val[28] ? hold_val[15:0] : 16'h0)});
            end
            if (req_v) reqv_seen = 1'b1;
            if (req_v && req_ready) begin
                gq.push_back({req_we, req_addr, req_wdata});
                gcyc.push_back(cyc);
            end
            if (rd_v) rdv_seen = 1'b1;
            if (rd_v && rd_ready) pq.push_back({rd_last, rd_data});
            if (done) begin
                if (done_cnt == 0) done_cyc = cyc;
                done_cnt++;
            end
            if (wd_ready) wdr_cnt++;
            hold_prev = req_v && !req_ready;
            hold_val  = {req_we, req_addr, req_wdata};
        end else begin
            hold_prev = 1'b0;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached before the summary");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        gq.delete();
        gcyc.delete();
        pq.delete();
        done_cnt  = 0;
        done_cyc  = -1;
        wdr_cnt   = 0;
        rdv_seen  = 1'b0;
        reqv_seen = 1'b0;
    endtask

    task automatic send_cmd(input logic we, input logic [11:0] base, input logic [11:0] stride,
                            input logic [7:0] len);
        cmd_v      = 1'b1;
        cmd_we     = we;
        cmd_base   = base;
        cmd_stride = stride;
        cmd_len    = len;
        acc_cyc    = cyc;
        step();
        cmd_v = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        for (int i = 0; i < budget; i++) begin
            if (done_cnt > 0) break;
            step();
        end
        chk(tag, (done_cnt > 0), 1);
    endtask

    initial begin
        rst_n      = 1'b0;
        cmd_v      = 1'b0;
        cmd_we     = 1'b0;
        cmd_base   = '0;
        cmd_stride = '0;
        cmd_len    = '0;
        wd_v       = 1'b0;
        wd_data    = '0;
        req_ready  = 1'b1;
        rd_ready   = 1'b1;

        // Reset state
        #12;
        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_outputs", {req_v, wd_ready, rd_v, busy, done, err, rd_last}, 7'b0);
        #1 rst_n = 1'b1;
        step();

        // 1: read base 0x010 stride 1 len 4
        clear_logs();
        send_cmd(1'b0, 12'h010, 12'h001, 8'd4);
        wait_done("t1_done_timeout", 20);
        repeat (3) step();
        chk("t1_ngrant", gq.size(), 4);
        for (int i = 0; i < 4 && i < gq.size(); i++) begin
            chk($sformatf("t1_addr%0d", i), {3'b0, gq[i][28:16]}, {4'b0, 12'h010 + 12'(i)});
            chk($sformatf("t1_gcyc%0d", i), gcyc[i], acc_cyc + 1 + i);
        end
        chk("t1_npop", pq.size(), 4);
        if (pq.size() == 4) begin
            chk("t1_pop0", pq[0], {1'b0, 16'h5A4A});
            chk("t1_pop1", pq[1], {1'b0, 16'h5A4B});
            chk("t1_pop2", pq[2], {1'b0, 16'h5A48});
            chk("t1_pop3", pq[3], {1'b1, 16'h5A49});
        end
        chk("t1_done_cnt", done_cnt, 1);
        if (gcyc.size() == 4) chk("t1_done_cyc", done_cyc, gcyc[3] + 2);

        // 2: read len 8 with rd_ready low, credit stops at FIFO depth
        clear_logs();
        rd_ready = 1'b0;
        send_cmd(1'b0, 12'h100, 12'h001, 8'd8);
        repeat (10) step();
        chk("t2_ngrant_stall", gq.size(), 4);
        chk("t2_req_v_stall", req_v, 0);
        chk("t2_busy_stall", busy, 1);
        rd_ready = 1'b1;
        wait_done("t2_done_timeout", 40);
        repeat (4) step();
        chk("t2_ngrant", gq.size(), 8);
        chk("t2_npop", pq.size(), 8);
        for (int i = 0; i < 8 && i < pq.size(); i++) begin
            chk($sformatf("t2_pop%0d", i), pq[i],
                {(i == 7), (16'h0100 + 16'(i)) ^ 16'h5A5A});
        end
        chk("t2_err", err, 0);

        // 3: write base 0xFF8 stride 8 len 3, producer gaps and arbiter denial
        clear_logs();
        send_cmd(1'b1, 12'hFF8, 12'h008, 8'd3);
        wd_v = 1'b0; wd_data = 16'h0000; req_ready = 1'b1;
        step();
        wd_v = 1'b1; wd_data = 16'hA001;
        step();
        wd_v = 1'b0; wd_data = 16'h0000;
        step();
        wd_v = 1'b1; wd_data = 16'hA002; req_ready = 1'b0;
        @(negedge clk);
        chk("t3_hold_a", {req_v, wd_ready, req_addr, req_wdata}, {1'b1, 1'b0, 12'h000, 16'hA002});
        step();
        @(negedge clk);
        chk("t3_hold_b", {req_v, wd_ready, req_addr, req_wdata}, {1'b1, 1'b0, 12'h000, 16'hA002});
        step();
        req_ready = 1'b1;
        step();
        wd_data = 16'hA003;
        step();
        wd_v = 1'b0; wd_data = 16'h0000;
        wait_done("t3_done_timeout", 20);
        repeat (2) step();
        chk("t3_ngrant", gq.size(), 3);
        if (gq.size() == 3) begin
            chk("t3_g0", gq[0], {1'b1, 12'hFF8, 16'hA001});
            chk("t3_g1", gq[1], {1'b1, 12'h000, 16'hA002});
            chk("t3_g2", gq[2], {1'b1, 12'h008, 16'hA003});
        end
        chk("t3_wd_ready_cnt", wdr_cnt, 3);
        chk("t3_rd_v_never", rdv_seen, 0);
        chk("t3_done_cnt", done_cnt, 1);

        // 4: zero-length command
        clear_logs();
        send_cmd(1'b0, 12'h123, 12'h001, 8'd0);
        wait_done("t4_done_timeout", 10);
        chk("t4_done_cyc", done_cyc, acc_cyc + 2);
        step();
        chk("t4_cmd_ready", cmd_ready, 1);
        chk("t4_no_req", reqv_seen, 0);
        chk("t4_done_cnt", done_cnt, 1);

        // 5: missing read response sets sticky err
        chk("t5_err_before", err, 0);
        clear_logs();
        drop_rsp = 1'b1;
        send_cmd(1'b0, 12'h020, 12'h001, 8'd2);
        wait_done("t5_done_timeout", 20);
        drop_rsp = 1'b0;
        repeat (3) step();
        chk("t5_err_set", err, 1);
        chk("t5_no_push", pq.size(), 0);
        clear_logs();
        send_cmd(1'b0, 12'h030, 12'h001, 8'd1);
        wait_done("t5b_done_timeout", 20);
        repeat (3) step();
        chk("t5_err_sticky", err, 1);
        chk("t5b_npop", pq.size(), 1);
        if (pq.size() == 1) chk("t5b_pop0", pq[0], {1'b1, 16'h5A6A});

        // 6: asynchronous reset in the middle of a read burst
        clear_logs();
        rd_ready = 1'b0;
        send_cmd(1'b0, 12'h200, 12'h001, 8'd8);
        repeat (3) step();
        chk("t6_pre_active", {req_v, rd_v, busy}, 3'b111);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_async_drop", {req_v, rd_v, busy, rd_last}, 4'b0000);
        chk("t6_async_cmd_ready", cmd_ready, 1);
        repeat (2) step();
        #2 rst_n = 1'b1;
        step();
        chk("t6_fifo_empty", rd_v, 0);
        chk("t6_err_cleared", err, 0);
        clear_logs();
        rd_ready = 1'b1;
        send_cmd(1'b0, 12'h300, 12'h002, 8'd2);
        wait_done("t6_done_timeout", 20);
        repeat (3) step();
        chk("t6_ngrant", gq.size(), 2);
        if (gq.size() == 2) begin
            chk("t6_addr0", {3'b0, gq[0][28:16]}, {4'b0, 12'h300});
            chk("t6_addr1", {3'b0, gq[1][28:16]}, {4'b0, 12'h302});
        end
        chk("t6_npop", pq.size(), 2);
        if (pq.size() == 2) begin
            chk("t6_pop0", pq[0], {1'b0, 16'h595A});
            chk("t6_pop1", pq[1], {1'b1, 16'h5958});
        end
        chk("t6_err", err, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
